// File: rtl/trap_event_recorder_if.sv
// Trap/return event recorder bus: event inputs,
// record stream with valid/ready, and status.
interface trap_event_recorder_if #(
  parameter int SEQW = 16
) ();
  logic            trap_valid;
  logic            trap_is_intr;
  logic            ret_valid;
  logic [7:0]      cause;
  logic [31:0]     epc;
  logic [31:0]     tval;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_kind;
  logic [SEQW-1:0] out_seq;
  logic [7:0]      out_cause;
  logic [31:0]     out_epc;
  logic [31:0]     out_tval;
  logic [SEQW-1:0] drop_count;
  logic            conflict;

  modport master (
    output trap_valid,
    output trap_is_intr,
    output ret_valid,
    output cause,
    output epc,
    output tval,
    output out_ready,
    input  out_valid,
    input  out_kind,
    input  out_seq,
    input  out_cause,
    input  out_epc,
    input  out_tval,
    input  drop_count,
    input  conflict
  );

  modport slave (
    input  trap_valid,
    input  trap_is_intr,
    input  ret_valid,
    input  cause,
    input  epc,
    input  tval,
    input  out_ready,
    output out_valid,
    output out_kind,
    output out_seq,
    output out_cause,
    output out_epc,
    output out_tval,
    output drop_count,
    output conflict
  );
endinterface

// File: rtl/trap_event_recorder.sv
// Records CSR trap/xRET events with sequence numbers
// into a small FIFO; counts drops when full.
module trap_event_recorder #(
  parameter int DEPTH = 4,
  parameter int SEQW  = 16
) (
  input logic clock,
  input logic reset,
  trap_event_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]      kind;
    logic [SEQW-1:0] seq;
    logic [7:0]      cause;
    logic [31:0]     epc;
    logic [31:0]     tval;
  } rec_t;

  rec_t            mem_q [DEPTH];
  logic [AW:0]     wr_q, wr_d;
  logic [AW:0]     rd_q, rd_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [SEQW-1:0] drop_q, drop_d;
  logic            conf_q, conf_d;

  logic [AW:0]     occ;
  logic            empty;
  logic            full;
  logic            evt;
  logic            pop;
  logic            push;
  rec_t            wr_rec;
  rec_t            head;

  always_comb begin
    occ   = wr_q - rd_q;
    empty = (wr_q == rd_q);
    full  = (occ == (AW+1)'(DEPTH));
    evt   = bus.trap_valid | bus.ret_valid;
    pop   = ~empty & bus.out_ready;
    // a pop on the same edge frees the slot
    push  = evt & (~full | pop);
  end

  // traps win over a coincident return
  always_comb begin
    wr_rec.seq = seq_q;
    wr_rec.epc = bus.epc;
    if (bus.trap_valid) begin
      wr_rec.kind  = bus.trap_is_intr ? 2'b10 : 2'b01;
      wr_rec.cause = bus.cause;
      wr_rec.tval  = bus.tval;
    end else begin
      wr_rec.kind  = 2'b11;
      wr_rec.cause = 8'h00;
      wr_rec.tval  = 32'h0;
    end
  end

  always_comb begin
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    seq_d  = evt  ? seq_q + 1'b1 : seq_q;
    drop_d = drop_q;
    if (evt && !push && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
    conf_d = conf_q |
             (bus.trap_valid & bus.ret_valid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      seq_q  <= '0;
      drop_q <= '0;
      conf_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      seq_q  <= seq_d;
      drop_q <= drop_d;
      conf_q <= conf_d;
    end
  end

  // storage needs no reset; outputs are gated by empty
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_q[AW-1:0]] <= wr_rec;
    end
  end

  always_comb begin
    head = mem_q[rd_q[AW-1:0]];
    if (empty) begin
      head = '0;
    end
  end

  assign bus.out_valid  = ~empty;
  assign bus.out_kind   = head.kind;
  assign bus.out_seq    = head.seq;
  assign bus.out_cause  = head.cause;
  assign bus.out_epc    = head.epc;
  assign bus.out_tval   = head.tval;
  assign bus.drop_count = drop_q;
  assign bus.conflict   = conf_q;

endmodule
